periph_rx_arbiter: RTL
======================

Name: periph_rx_arbiter

Overview:
- Round-robin arbiter that drains the per-peripheral local RX FIFOs into the single shared USB-bound FIFO.
- Each packet is prefixed with the source peripheral's address, so the host can demultiplexe by address.
- Sits between the reconfigurable-peripheral slots and the USB FT601 write path.
- Guarantees fairness: no peripheral streaming continuously can starve the others.

Parameters:
- NUM_PERIPHS, 2**periph_address_width (8): number of peripheral slots arbitrated.
- ADDR_W, periph_address_width (3): width of the address prefix.
- PKT_W, usb_packet_width (32): full USB packet width.
- PAYLOAD_W, PKT_W-ADDR_W (29): width of a peripheral payload.
- BURST_LEN, 4: maximum packets per grant. Used only when LYCAN_RX_ARB_BURST_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- periph_rx_data  in  NUM_PERIPHS*PAYLOAD_W  flattened local-FIFO read data; slot i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
- periph_rx_empty  in  NUM_PERIPHS  local-FIFO empty flags
- periph_rx_rden  out  NUM_PERIPHS  local-FIFO read enables, one-hot or zero
- usb_tx_data  out  PKT_W  {ADDR_W address, PAYLOAD_W payload}; address in the MSBs
- usb_tx_wren  out  1  write strobe to the shared FIFO
- usb_tx_full  in  1  shared FIFO full
- grant  out  ADDR_W  currently or most recently granted slot
- idle  out  1  high when in IDLE and all periph_rx_empty bits are high

Behaviour:
- Single clock domain. Reset is asynchronous, active-high, port named rst; clock port named clk.
- Reset values:
  - state = IDLE
  - periph_rx_rden = 0, usb_tx_wren = 0, usb_tx_data = 0
  - grant = 0, last_grant = NUM_PERIPHS-1, so slot 0 has priority first
  - idle is combinational; it reads 1 after reset only if all FIFOs are empty.
- Local and shared FIFOs are standard (non-FWFT): read data is valid exactly 1 cycle after rden.
- State machine, states IDLE, READ, CAPTURE, WRITE:
  - IDLE: if any empty bit is low, select the first non-empty slot scanning last_grant+1 upward with wrap. In the same registered step, set grant, pulse periph_rx_rden[grant] for exactly 1 cycle, and go to READ. Otherwise stay in IDLE.
  - READ: rden deasserted; go to CAPTURE.
  - CAPTURE: register usb_tx_data <= {grant, periph_rx_data[grant]}; go to WRITE.
  - WRITE: usb_tx_wren = !usb_tx_full (combinational from state). On the cycle wren is high the packet is accepted: set last_grant <= grant and go to IDLE. While full, hold data and state indefinitely; no timeout.
- rden is never asserted for an empty slot. At most one rden bit is high in any cycle.
- Throughput without burst: one packet per 4 cycles, arbitration included.
- Wrap-around: when last_grant = NUM_PERIPHS-1, the scan starts at slot 0.
- A slot whose empty flag rises between arbitration and read does not occur, because only the arbiter reads. Empty is sampled only in IDLE.
- Reset mid-operation: returns immediately to IDLE. A packet already popped but not yet written is dropped, and the peripheral FIFOs are reset alongside.

Optional Feature:
- Macro: LYCAN_RX_ARB_BURST_EN.
- Defined: a 2-bit-minimum burst counter, cleared on grant, counts accepted writes. In WRITE, on acceptance, if the count < BURST_LEN-1 and periph_rx_empty[grant] is low, pulse rden[grant] again and go to READ, keeping the same grant. Otherwise go to IDLE with last_grant <= grant.
- Undefined: the counter logic is absent and each grant carries exactly 1 packet.

Decomposition:
- lycan_globals holds:
  - usb_packet_width and periph_address_width (existing)
  - new typedef rx_arb_state_t (enum IDLE, READ, CAPTURE, WRITE)
  - new constant num_peripherals = 2**periph_address_width
- One sub-module, rr_priority_select: combinational round-robin picker with inputs request vector and last_grant, outputs valid and index. It is reusable for a future TX-side dispatcher.

Test Plan:
1. Reset with all FIFOs empty -> all outputs 0, idle=1, no rden for 20 cycles.
2. Only slot 5 has one packet with payload 0x0ABCDEF -> rden[5] pulses once; 3 cycles later usb_tx_wren=1 with data {3'd5, 29'h0ABCDEF}; idle returns to 1.
3. Slots 0, 3 and 7 each hold 3 packets (burst off) -> grant order 0,3,7,0,3,7,0,3,7; 9 writes total; never two consecutive writes from one slot while others are pending.
4. usb_tx_full held high for 10 cycles while in WRITE -> wren stays 0, data stable, no further rden; on release, exactly one write occurs.
5. rst asserted while in CAPTURE -> next edge shows state IDLE with all outputs 0; after rst drops, arbitration restarts at slot 0.
6. Burst on (BURST_LEN=4): slot 2 holds 6 packets and slot 4 holds 1 -> grant sequence 2,2,2,2,4,2,2.

Source files
------------

// File: rtl/periph_rx_arbiter_pkg.sv
// Shared constants and types for the Lycan peripheral/USB datapath.
// Holds the USB packet geometry, the peripheral slot count derived from the
// address width, and the state type used by the RX-side arbiter.
package lycan_globals;

    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;
    localparam int num_peripherals      = 2 ** periph_address_width;

    // Maximum packets a single grant may carry when bursting is compiled in.
    localparam int rx_arb_burst_len     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } rx_arb_state_t;

    // The burst counter needs to reach BURST_LEN-1, but never shrinks below
    // two bits so a tiny BURST_LEN still gets a well-formed comparison.
    function automatic int burstCountWidth(input int burstLen);
        int w;
        w = (burstLen > 1) ? $clog2(burstLen) : 1;
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/periph_rx_arbiter_rr_priority_select.sv
// Combinational round-robin picker. Given a request vector and the index that
// was served last, returns the first requesting index strictly after it,
// wrapping around, so the last-served requester has the lowest priority.
// Kept generic so the TX-side dispatcher can reuse it.
module rr_priority_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    // Walk candidates from the furthest to the nearest so the nearest
    // requester after last_i is the one left standing.
    always_comb begin
        int cand;
        logic [IDX_W-1:0] candIdx;
        valid_o = 1'b0;
        index_o = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = N; k >= 1; k--) begin
            cand    = (int'(last_i) + k) % N;
            candIdx = IDX_W'(cand);
            if (req_i[candIdx]) begin
                valid_o = 1'b1;
                index_o = candIdx;
            end
        end
    end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Round-robin arbiter draining the per-peripheral local RX FIFOs into the
// shared USB-bound FIFO. Each packet carries the source slot address in its
// MSBs so the host can demultiplex. All FIFOs are standard (non-FWFT), so a
// pop takes READ (rden high) then CAPTURE (data valid) before WRITE.
// Optional feature: define LYCAN_RX_ARB_BURST_EN to let one grant carry up to
// BURST_LEN packets from the same slot before re-arbitrating.
module periph_rx_arbiter
    import lycan_globals::*;
#(
    parameter int NUM_PERIPHS = num_peripherals,
    parameter int ADDR_W      = periph_address_width,
    parameter int PKT_W       = usb_packet_width,
    parameter int PAYLOAD_W   = PKT_W - ADDR_W
`ifdef LYCAN_RX_ARB_BURST_EN
    ,
    parameter int BURST_LEN   = rx_arb_burst_len
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PERIPHS*PAYLOAD_W-1:0] periph_rx_data,
    input  logic [NUM_PERIPHS-1:0]         periph_rx_empty,
    output logic [NUM_PERIPHS-1:0]         periph_rx_rden,
    output logic [PKT_W-1:0]               usb_tx_data,
    output logic                           usb_tx_wren,
    input  logic                           usb_tx_full,
    output logic [ADDR_W-1:0]              grant,
    output logic                           idle
);

`ifdef LYCAN_RX_ARB_BURST_EN
    localparam int CNT_W = burstCountWidth(BURST_LEN);
`endif

    rx_arb_state_t            state_q, state_d;
    logic [ADDR_W-1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0]        lastGrant_q, lastGrant_d;
    logic [NUM_PERIPHS-1:0]   rden_q, rden_d;
    logic [PKT_W-1:0]         data_q, data_d;
`ifdef LYCAN_RX_ARB_BURST_EN
    logic [CNT_W-1:0]         burstCnt_q, burstCnt_d;
`endif

    logic                     selValid;
    logic [ADDR_W-1:0]        selIdx;
    logic [PAYLOAD_W-1:0]     slotData [NUM_PERIPHS];

    for (genvar g = 0; g < NUM_PERIPHS; g++) begin : gSlot
        assign slotData[g] = periph_rx_data[g*PAYLOAD_W +: PAYLOAD_W];
    end

    // A slot is a candidate whenever its local FIFO holds data.
    rr_priority_select #(
        .N     (NUM_PERIPHS),
        .IDX_W (ADDR_W)
    ) uSelect (
        .req_i   (~periph_rx_empty),
        .last_i  (lastGrant_q),
        .valid_o (selValid),
        .index_o (selIdx)
    );

    // Registered state; last_grant starts at the top slot so slot 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= ADDR_W'(NUM_PERIPHS - 1);
            rden_q      <= '0;
            data_q      <= '0;
`ifdef LYCAN_RX_ARB_BURST_EN
            burstCnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            rden_q      <= rden_d;
            data_q      <= data_d;
`ifdef LYCAN_RX_ARB_BURST_EN
            burstCnt_q  <= burstCnt_d;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE, pop, capture, then hand to USB.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        rden_d      = '0;
        data_d      = data_q;
`ifdef LYCAN_RX_ARB_BURST_EN
        burstCnt_d  = burstCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (selValid) begin
                    grant_d        = selIdx;
                    rden_d[selIdx] = 1'b1;
                    state_d        = READ;
`ifdef LYCAN_RX_ARB_BURST_EN
                    burstCnt_d     = '0;
`endif
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = {grant_q, slotData[grant_q]};
                state_d = WRITE;
            end
            WRITE: begin
                if (!usb_tx_full) begin
`ifdef LYCAN_RX_ARB_BURST_EN
                    if ((burstCnt_q < CNT_W'(BURST_LEN - 1)) && !periph_rx_empty[grant_q]) begin
                        burstCnt_d      = burstCnt_q + 1'b1;
                        rden_d[grant_q] = 1'b1;
                        state_d         = READ;
                    end else begin
                        lastGrant_d = grant_q;
                        state_d     = IDLE;
                    end
`else
                    lastGrant_d = grant_q;
                    state_d     = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign periph_rx_rden = rden_q;
    assign usb_tx_data    = data_q;
    assign usb_tx_wren    = (state_q == WRITE) && !usb_tx_full;
    assign grant          = grant_q;
    assign idle           = (state_q == IDLE) && (&periph_rx_empty);

endmodule
